// File: rtl/bin2bcd_if.sv
// Handshake and result bundle for bin2bcd_seq: the controller drives start/bin,
// and the converter returns busy/done plus the packed BCD, ASCII and overflow results.
interface bin2bcd_if #(
    parameter int W      = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [W-1:0]          bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic [8*DIGITS-1:0]   ascii;
    logic                  ovf;

    modport master (
        output start, bin,
        input  busy, done, bcd, ascii, ovf
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, ascii, ovf
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with ASCII digit output and an overflow flag when DIGITS cannot hold the value.
module bin2bcd_seq #(
    parameter int W      = 8,
    parameter int DIGITS = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    bin2bcd_if.slave   bus
);
    localparam int CW = $clog2(W + 1);
    localparam int BW = 4 * DIGITS;
    localparam int AW = 8 * DIGITS;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    shift_q, shift_d;
    logic [BW-1:0]   work_q, work_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            acc_q, acc_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            ovf_q, ovf_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic [AW-1:0]   ascii_q, ascii_d;

    logic [BW-1:0]   adj_s;
    logic [BW-1:0]   work_next_s;
    logic            acc_next_s;

    // Add 3 to every digit >= 5; digits are independent, no carry between them.
    function automatic logic [BW-1:0] dabble_adjust(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = v[4*i +: 4] + 4'd3;
            end else begin
                r[4*i +: 4] = v[4*i +: 4];
            end
        end
        return r;
    endfunction

    function automatic logic [AW-1:0] to_ascii(input logic [BW-1:0] b);
        logic [AW-1:0] r;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[8*i +: 8] = {4'h3, b[4*i +: 4]};
        end
        return r;
    endfunction

    // Next-state, datapath and output-register computation.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;
        bcd_d   = bcd_q;
        ascii_d = ascii_q;

        adj_s       = dabble_adjust(work_q);
        work_next_s = {adj_s[BW-2:0], shift_q[W-1]};
        // The bit leaving the top digit would belong to a digit we do not keep.
        acc_next_s  = acc_q | adj_s[BW-1];

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    shift_d = bus.bin;
                    work_d  = '0;
                    cnt_d   = '0;
                    acc_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = CONV;
                end else begin
                    state_d = IDLE;
                end
            end
            CONV: begin
                work_d  = work_next_s;
                shift_d = shift_q << 1;
                acc_d   = acc_next_s;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(W - 1)) begin
                    bcd_d   = work_next_s;
                    ascii_d = to_ascii(work_next_s);
                    ovf_d   = acc_next_s;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    state_d = CONV;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            bcd_q   <= '0;
            ascii_q <= {DIGITS{8'h30}};
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            bcd_q   <= bcd_d;
            ascii_q <= ascii_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.bcd   = bcd_q;
    assign bus.ascii = ascii_q;
    assign bus.ovf   = ovf_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq across four W/DIGITS configurations,
// using hand-written vectors plus a decimal reference model for random inputs.
module tb_bin2bcd_seq;
    logic        clk;
    logic        rst_n;
    logic [15:0] bin_v;
    logic [3:0]  start_v;

    int checks;
    int failures;

    bin2bcd_if #(.W(8),  .DIGITS(3)) ia();
    bin2bcd_if #(.W(8),  .DIGITS(2)) ib();
    bin2bcd_if #(.W(16), .DIGITS(5)) ic();
    bin2bcd_if #(.W(10), .DIGITS(4)) id();

    assign ia.start = start_v[0];
    assign ia.bin   = bin_v[7:0];
    assign ib.start = start_v[1];
    assign ib.bin   = bin_v[7:0];
    assign ic.start = start_v[2];
    assign ic.bin   = bin_v;
    assign id.start = start_v[3];
    assign id.bin   = bin_v[9:0];

    bin2bcd_seq #(.W(8),  .DIGITS(3)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    bin2bcd_seq #(.W(8),  .DIGITS(2)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib));
    bin2bcd_seq #(.W(16), .DIGITS(5)) u_c (.clk(clk), .rst_n(rst_n), .bus(ic));
    bin2bcd_seq #(.W(10), .DIGITS(4)) u_d (.clk(clk), .rst_n(rst_n), .bus(id));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic sel_done(input int idx);
        case (idx)
            0: return ia.done;
            1: return ib.done;
            2: return ic.done;
            3: return id.done;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic sel_busy(input int idx);
        case (idx)
            0: return ia.busy;
            1: return ib.busy;
            2: return ic.busy;
            3: return id.busy;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic sel_ovf(input int idx);
        case (idx)
            0: return ia.ovf;
            1: return ib.ovf;
            2: return ic.ovf;
            3: return id.ovf;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [63:0] sel_bcd(input int idx);
        case (idx)
            0: return 64'(ia.bcd);
            1: return 64'(ib.bcd);
            2: return 64'(ic.bcd);
            3: return 64'(id.bcd);
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [127:0] sel_ascii(input int idx);
        case (idx)
            0: return 128'(ia.ascii);
            1: return 128'(ib.ascii);
            2: return 128'(ic.ascii);
            3: return 128'(id.ascii);
            default: return 128'd0;
        endcase
    endfunction

    function automatic int digits_of(input int idx);
        case (idx)
            0: return 3;
            1: return 2;
            2: return 5;
            3: return 4;
            default: return 1;
        endcase
    endfunction

    // Decimal reference: the low d digits of v, and whether v needs more than d digits.
    function automatic logic [63:0] ref_bcd(input longint unsigned v, input int d);
        logic [63:0] r;
        r = 64'd0;
        for (int i = 0; i < d; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [127:0] ref_ascii(input longint unsigned v, input int d);
        logic [127:0] r;
        r = 128'd0;
        for (int i = 0; i < d; i++) begin
            r[8*i +: 8] = 8'h30 + 8'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input longint unsigned v, input int d);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return (v >= p);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Counts edges from n0 until done is seen, bounded so a stuck DUT still ends the run.
    task automatic wait_done(input int idx, input int n0, output int n, output logic ok);
        n  = n0;
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            n++;
            if (sel_done(idx)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic launch(input int idx, input logic [15:0] v);
        @(negedge clk);
        bin_v        = v;
        start_v[idx] = 1'b1;
        @(posedge clk);
        #1;
        start_v[idx] = 1'b0;
    endtask

    task automatic run(input int idx, input logic [15:0] v, output int lat, output logic ok);
        launch(idx, v);
        wait_done(idx, 0, lat, ok);
    endtask

    typedef struct {
        int           idx;
        int unsigned  v;
        logic [63:0]  bcd;
        logic [127:0] ascii;
        logic         ovf;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int   lat;
        int   n;
        logic ok;
        logic bad_digit;
        int   r;
        int   v;

        checks   = 0;
        failures = 0;
        start_v  = 4'b0;
        bin_v    = 16'd0;
        rst_n    = 1'b0;

        tbl[0] = '{0, 255, 64'h255, 128'h323535, 1'b0};
        tbl[1] = '{0, 0,   64'h000, 128'h303030, 1'b0};
        tbl[2] = '{0, 99,  64'h099, 128'h303939, 1'b0};
        tbl[3] = '{0, 7,   64'h007, 128'h303037, 1'b0};
        tbl[4] = '{1, 255, 64'h55,  128'h3535,   1'b1};
        tbl[5] = '{1, 99,  64'h99,  128'h3939,   1'b0};
        tbl[6] = '{1, 100, 64'h00,  128'h3030,   1'b1};
        tbl[7] = '{1, 10,  64'h10,  128'h3130,   1'b0};
        tbl[8] = '{2, 65535, 64'h65535, 128'h3635353335, 1'b0};

        #12;
        chk("reset_busy",  128'(ia.busy),  128'd0);
        chk("reset_done",  128'(ia.done),  128'd0);
        chk("reset_bcd",   128'(ia.bcd),   128'd0);
        chk("reset_ascii", 128'(ia.ascii), 128'h303030);
        chk("reset_ovf",   128'(ia.ovf),   128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run(tbl[i].idx, 16'(tbl[i].v), lat, ok);
            chk($sformatf("tbl%0d_done_seen", i), 128'(ok), 128'd1);
            chk($sformatf("tbl%0d_latency", i), 128'(lat), (tbl[i].idx == 2) ? 128'd16 : 128'd8);
            chk($sformatf("tbl%0d_bcd", i),   128'(sel_bcd(tbl[i].idx)), 128'(tbl[i].bcd));
            chk($sformatf("tbl%0d_ascii", i), sel_ascii(tbl[i].idx), tbl[i].ascii);
            chk($sformatf("tbl%0d_ovf", i),   128'(sel_ovf(tbl[i].idx)), 128'(tbl[i].ovf));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_done_one_cycle", i), 128'(sel_done(tbl[i].idx)), 128'd0);
            chk($sformatf("tbl%0d_bcd_held", i), 128'(sel_bcd(tbl[i].idx)), 128'(tbl[i].bcd));
        end

        // start pulsed 3 cycles into a running conversion must be ignored
        launch(0, 16'd123);
        repeat (3) @(posedge clk);
        #1;
        bin_v      = 16'd200;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        wait_done(0, 4, n, ok);
        chk("ignore_start_done_seen", 128'(ok), 128'd1);
        chk("ignore_start_latency", 128'(n), 128'd8);
        chk("ignore_start_bcd", 128'(ia.bcd), 128'h123);
        @(posedge clk);
        #1;
        chk("ignore_start_no_restart", 128'(ia.busy), 128'd0);

        // back-to-back: start held in the done cycle
        run(0, 16'd12, lat, ok);
        chk("b2b_first_bcd", 128'(ia.bcd), 128'h012);
        chk("b2b_done_cycle_idle", 128'(ia.busy), 128'd0);
        bin_v      = 16'd45;
        start_v[0] = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        chk("b2b_busy_after_accept", 128'(ia.busy), 128'd1);
        chk("b2b_done_dropped", 128'(ia.done), 128'd0);
        wait_done(0, 1, n, ok);
        chk("b2b_done_seen", 128'(ok), 128'd1);
        chk("b2b_spacing", 128'(n), 128'd9);
        chk("b2b_bcd", 128'(ia.bcd), 128'h045);
        chk("b2b_ascii", 128'(ia.ascii), 128'h303435);

        // bin changed mid-conversion has no effect
        launch(2, 16'd1234);
        repeat (5) @(posedge clk);
        #1;
        bin_v = 16'd9999;
        wait_done(2, 5, n, ok);
        chk("midbin_latency", 128'(n), 128'd16);
        chk("midbin_bcd", 128'(ic.bcd), 128'h01234);

        // random 16-bit conversions against the decimal model
        for (int i = 0; i < 20; i++) begin
            v = int'($urandom_range(0, 65535));
            run(2, 16'(v), lat, ok);
            chk($sformatf("rand16_bcd v=%0d", v), 128'(ic.bcd), 128'(ref_bcd(longint'(v), 5)));
            chk($sformatf("rand16_ascii v=%0d", v), 128'(ic.ascii), ref_ascii(longint'(v), 5));
        end

        // reset asserted mid-conversion of 200 acts without a clock edge
        launch(0, 16'd200);
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midreset_busy",  128'(ia.busy),  128'd0);
        chk("midreset_done",  128'(ia.done),  128'd0);
        chk("midreset_bcd",   128'(ia.bcd),   128'd0);
        chk("midreset_ascii", 128'(ia.ascii), 128'h303030);
        chk("midreset_ovf",   128'(ib.ovf),   128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(0, 16'd88, lat, ok);
        chk("post_reset_latency", 128'(lat), 128'd8);
        chk("post_reset_bcd", 128'(ia.bcd), 128'h088);

        // full 10-bit sweep in a random permutation (odd stride is a bijection mod 1024)
        r = int'($urandom_range(0, 1023));
        for (int i = 0; i < 1024; i++) begin
            v = (i * 337 + r) % 1024;
            run(3, 16'(v), lat, ok);
            bad_digit = 1'b0;
            for (int d = 0; d < 4; d++) begin
                if (id.bcd[4*d +: 4] > 4'd9) bad_digit = 1'b1;
            end
            chk($sformatf("sweep_done v=%0d", v), 128'(ok), 128'd1);
            chk($sformatf("sweep_bcd v=%0d", v), 128'(id.bcd), 128'(ref_bcd(longint'(v), 4)));
            chk($sformatf("sweep_digit_range v=%0d", v), 128'(bad_digit), 128'd0);
            chk($sformatf("sweep_ovf v=%0d", v), 128'(id.ovf), 128'(ref_ovf(longint'(v), digits_of(3))));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bin2bcd_seq.md
# bin2bcd_seq

Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It replaces per-digit combinational add-3 cells with a single registered datapath that scales to any input width and digit count. It also emits ASCII digit characters directly for the ASCII adder display/transmit path. A start/busy/done handshake lets a controller issue back-to-back conversions.

## Interface
- W, default 8: binary input width, 1..32.
- DIGITS, default 3: number of BCD output digits, 1..10. Not required to cover 2^W-1; see `ovf`.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a conversion. Sampled only when `busy`=0.
- bin  in  W  unsigned binary operand, captured on the accepting edge.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when results update.
- bcd  out  4*DIGITS  packed BCD. Digit 0 (units) is in [3:0].
- ascii  out  8*DIGITS  ASCII digits: byte i = 8'h30 | digit i. Most significant digit is in the top byte. Leading zeros are kept ('0').
- ovf  out  1  result did not fit in DIGITS digits; `bcd`/`ascii` then hold the low-order digits (value mod 10^DIGITS).

## Operation
- States: IDLE, CONV.
- IDLE with `start`=1 at an edge:
  - shift reg ← `bin`
  - working BCD reg ← 0
  - bit counter ← 0
  - overflow accumulator ← 0
  - state → CONV, `busy` → 1
- CONV, each edge:
  - Every working digit ≥5 gets +3 (4-bit, no carry between digits).
  - Then shift {BCD reg, shift reg} left one bit; the shift-reg MSB enters BCD bit 0.
  - The bit shifted out of the top digit's MSB is ORed into the overflow accumulator.
  - Counter increments.
- When the W-th iteration's edge completes:
  - `bcd` ← shifted working BCD
  - `ascii` derived from `bcd`
  - `ovf` ← accumulator, including the final bit out
  - `done` = 1, `busy` = 0, state → IDLE
- `start` while `busy`=1 is ignored. No queuing, no effect on the running conversion.
- `bin` is not sampled after the accepting edge; changing it mid-conversion has no effect.
- `bcd`/`ascii`/`ovf` hold their last values until the next `done`.
- Digit values in `bcd` are always 0..9.
- Counter width is clog2(W+1).

## Timing
- Reset (asynchronous, any time, including mid-CONV) forces:
  - state IDLE
  - `busy`=0, `done`=0, `ovf`=0, `bcd`=0
  - `ascii`=all bytes 8'h30
  - in-flight conversion discarded
- Exit from reset is synchronous to `clk`. The first `start` is accepted on the first rising edge with `rst_n`=1.
- Latency: `start` accepted at edge k → `busy`=1 after edge k → `done`=1 and results valid after edge k+W, for exactly one cycle.
- Throughput: `done` is high while `busy` is low, so `start` may be asserted in the `done` cycle. It is accepted at edge k+W+1, giving W+1 cycles per conversion back-to-back.
- `start` and reset deasserting together: the `start` is accepted only if `rst_n` is high at the sampling edge.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Reset values, W=8, DIGITS=3:
  - assert `rst_n`=0 mid-conversion of 200 → `busy`=0, `done`=0, `bcd`=12'h000, `ascii`=24'h303030, `ovf`=0 immediately, without waiting for a clock edge.
- Basic conversions, W=8, DIGITS=3:
  - `bin`=255 → 8 cycles after acceptance `done`=1, `bcd`=12'h255, `ascii`=24'h323535, `ovf`=0.
  - `bin`=0 → `bcd`=12'h000.
  - `bin`=99 → `bcd`=12'h099, `ascii`=24'h303939.
- Handshake:
  - `start` pulsed 3 cycles into a conversion of 123 → ignored, result 12'h123.
  - `start` held during the `done` cycle with `bin`=45 → second `done` exactly 9 cycles after the first, `bcd`=12'h045.
- Overflow, W=8, DIGITS=2:
  - 255 → `ovf`=1, `bcd`=8'h55.
  - 99 → `ovf`=0, `bcd`=8'h99.
  - 100 → `ovf`=1, `bcd`=8'h00.
- Width scaling, W=16, DIGITS=5:
  - 65535 → `bcd`=20'h65535, `done` 16 cycles after acceptance.
  - `bin` changed mid-conversion → result unaffected.
- Randomised sweep, W=10, DIGITS=4: all 1024 inputs → `bcd` matches the decimal reference, every digit ≤9, `ovf`=0.
